// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU op scheduler: state encoding, op bit indices, op masks.
package fpu_sched_pkg;

  localparam int unsigned FPU_SELECT_W = 12;
  localparam int unsigned ADDR_W       = 4;

  localparam int unsigned OP_MVRF = 0;
  localparam int unsigned OP_MVFR = 1;
  localparam int unsigned OP_CRF  = 2;
  localparam int unsigned OP_CFR  = 3;
  localparam int unsigned OP_CURF = 4;
  localparam int unsigned OP_CUFR = 5;
  localparam int unsigned OP_FADD = 6;
  localparam int unsigned OP_FSUB = 7;
  localparam int unsigned OP_FMUL = 8;
  localparam int unsigned OP_FRC  = 9;
  localparam int unsigned OP_FGT  = 10;
  localparam int unsigned OP_FEQ  = 11;

  localparam logic [FPU_SELECT_W-1:0] MUL_OP_MASK =
    (FPU_SELECT_W'(1) << OP_FMUL) | (FPU_SELECT_W'(1) << OP_FRC);
  localparam logic [FPU_SELECT_W-1:0] ILLEGAL_OP_MASK =
    (FPU_SELECT_W'(1) << OP_CFR) | (FPU_SELECT_W'(1) << OP_CUFR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_MUL,
    ST_EXEC,
    ST_BAD
  } state_t;

  function automatic logic is_onehot(input logic [FPU_SELECT_W-1:0] v);
    return (v != '0) && ((v & (v - FPU_SELECT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Op request handshake bundle between the issuing datapath (master) and the scheduler (slave).
interface fpu_op_scheduler_if;
  import fpu_sched_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [FPU_SELECT_W-1:0] req_op;
  logic [ADDR_W-1:0]       req_a_addr;
  logic [ADDR_W-1:0]       req_b_addr;
  logic [ADDR_W-1:0]       req_z_addr;

  modport master (
    output req_valid, req_op, req_a_addr, req_b_addr, req_z_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_a_addr, req_b_addr, req_z_addr,
    output req_ready
  );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Shared ALU multiplier arbitration: combinational integer grant with a registered lock that
// keeps the integer datapath's ownership while it holds its request.
module fpu_mul_arbiter #(
  parameter int FPU_PRIORITY = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic int_mul_req,
  input  logic fpu_hold,
  input  logic fpu_claim,
  input  logic fpu_exec_mul,
  output logic int_mul_gnt,
  output logic alu_mul_owner
);

  logic lock;
  logic fpu_wants;

  // A fresh FPU claim only beats a simultaneous integer request when FPU has priority;
  // an already-locked integer grant is never revoked.
  always_comb begin
    fpu_wants   = fpu_hold | (fpu_claim & (FPU_PRIORITY != 0));
    int_mul_gnt = int_mul_req & (lock | ~fpu_wants);
  end

  always_ff @(posedge clk) begin
    if (clr) lock <= 1'b0;
    else     lock <= int_mul_gnt;
  end

  assign alu_mul_owner = fpu_exec_mul;

endmodule

// File: rtl/fpu_op_scheduler.sv
// FPU op sequencer with shared-multiplier arbitration.
// Optional FPU_SCHED_STATS_EN adds stat_ops / stat_mul_stall counters.
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int FRC_CYCLES   = 8,
  parameter int FPU_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  fpu_op_scheduler_if.slave       req,
  output logic [FPU_SELECT_W-1:0] fpu_select,
  output logic [ADDR_W-1:0]       fpu_a_addr,
  output logic [ADDR_W-1:0]       fpu_b_addr,
  output logic [ADDR_W-1:0]       fpu_z_addr,
  input  logic                    fpu_illegal,
  output logic                    done,
  output logic                    done_illegal,
  output logic                    busy,
  input  logic                    int_mul_req,
  output logic                    int_mul_gnt,
  output logic                    alu_mul_owner
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_ops,
  output logic [31:0]             stat_mul_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(FRC_CYCLES);

  state_t                  state, state_nxt;
  logic [FPU_SELECT_W-1:0] op_q;
  logic [ADDR_W-1:0]       a_q, b_q, z_q;
  logic [CNT_W-1:0]        cnt;

  logic accept, legal, req_is_mul, op_is_mul, exec_mul, fpu_hold, fpu_claim, last;

  always_comb begin
    accept     = (state == ST_IDLE) & req.req_valid;
    legal      = is_onehot(req.req_op);
    req_is_mul = |(req.req_op & MUL_OP_MASK);
    op_is_mul  = |(op_q & MUL_OP_MASK);
    exec_mul   = (state == ST_EXEC) & op_is_mul;
    fpu_hold   = (state == ST_WAIT_MUL) | exec_mul;
    fpu_claim  = accept & legal & req_is_mul;
    last       = (state == ST_EXEC) & (cnt == '0);
  end

  fpu_mul_arbiter #(
    .FPU_PRIORITY (FPU_PRIORITY)
  ) u_arb (
    .clk           (clk),
    .clr           (clr),
    .int_mul_req   (int_mul_req),
    .fpu_hold      (fpu_hold),
    .fpu_claim     (fpu_claim),
    .fpu_exec_mul  (exec_mul),
    .int_mul_gnt   (int_mul_gnt),
    .alu_mul_owner (alu_mul_owner)
  );

  always_comb begin
    state_nxt     = state;
    req.req_ready = 1'b0;
    busy          = 1'b1;
    fpu_select    = '0;
    done          = 1'b0;
    done_illegal  = 1'b0;
    case (state)
      ST_IDLE: begin
        req.req_ready = 1'b1;
        busy          = 1'b0;
        if (accept) begin
          if (!legal)                         state_nxt = ST_BAD;
          else if (req_is_mul && int_mul_gnt) state_nxt = ST_WAIT_MUL;
          else                                state_nxt = ST_EXEC;
        end
      end
      ST_WAIT_MUL: begin
        if (!int_mul_req) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        fpu_select = op_q;
        if (last) begin
          done         = 1'b1;
          done_illegal = fpu_illegal & (|(op_q & ILLEGAL_OP_MASK));
          state_nxt    = ST_IDLE;
        end
      end
      ST_BAD: begin
        done         = 1'b1;
        done_illegal = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      z_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req.req_op;
        a_q  <= req.req_a_addr;
        b_q  <= req.req_b_addr;
        z_q  <= req.req_z_addr;
        cnt  <= req.req_op[OP_FRC] ? CNT_W'(FRC_CYCLES - 1) : '0;
      end else if ((state == ST_EXEC) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign fpu_a_addr = a_q;
  assign fpu_b_addr = b_q;
  assign fpu_z_addr = z_q;

`ifdef FPU_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_ops       <= '0;
      stat_mul_stall <= '0;
    end else begin
      if (done)                   stat_ops       <= stat_ops + 32'd1;
      if (state == ST_WAIT_MUL)   stat_mul_stall <= stat_mul_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler (FRC_CYCLES=8, FPU_PRIORITY=1).
module tb_fpu_op_scheduler;

  logic        clk = 1'b0;
  logic        clr;
  logic [11:0] fpu_select;
  logic [3:0]  fpu_a_addr, fpu_b_addr, fpu_z_addr;
  logic        fpu_illegal, done, done_illegal, busy;
  logic        int_mul_req, int_mul_gnt, alu_mul_owner;
`ifdef FPU_SCHED_STATS_EN
  logic [31:0] stat_ops, stat_mul_stall;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  fpu_op_scheduler_if bus ();

  fpu_op_scheduler #(
    .FRC_CYCLES   (8),
    .FPU_PRIORITY (1)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .req           (bus.slave),
    .fpu_select    (fpu_select),
    .fpu_a_addr    (fpu_a_addr),
    .fpu_b_addr    (fpu_b_addr),
    .fpu_z_addr    (fpu_z_addr),
    .fpu_illegal   (fpu_illegal),
    .done          (done),
    .done_illegal  (done_illegal),
    .busy          (busy),
    .int_mul_req   (int_mul_req),
    .int_mul_gnt   (int_mul_gnt),
    .alu_mul_owner (alu_mul_owner)
`ifdef FPU_SCHED_STATS_EN
    ,
    .stat_ops       (stat_ops),
    .stat_mul_stall (stat_mul_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] z);
    bus.req_valid  = v;
    bus.req_op     = op;
    bus.req_a_addr = a;
    bus.req_b_addr = b;
    bus.req_z_addr = z;
  endtask

  initial begin
    clr = 1'b1; fpu_illegal = 1'b0; int_mul_req = 1'b0;
    drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0);
    tick(); tick(); #1;
    chk("rst_select", 32'(fpu_select), 32'h0);
    chk("rst_addr", {20'h0, fpu_a_addr, fpu_b_addr, fpu_z_addr}, 32'h0);
    chk("rst_flags", {done, done_illegal, busy, int_mul_gnt, alu_mul_owner}, 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
`ifdef FPU_SCHED_STATS_EN
    chk("rst_stats", stat_ops | stat_mul_stall, 32'h0);
`endif
    tick(); clr = 1'b0;

    // fadd single-cycle
    drive(1'b1, 12'h040, 4'h1, 4'h2, 4'h3); #1;
    chk("fadd_ready_idle", 32'(bus.req_ready), 32'h1);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("fadd_select", 32'(fpu_select), 32'h040);
    chk("fadd_addr", {20'h0, fpu_a_addr, fpu_b_addr, fpu_z_addr}, 32'h123);
    chk("fadd_done", {done, done_illegal, busy, bus.req_ready, alu_mul_owner}, 32'b10100);
    tick(); #1;
    chk("fadd_after", {20'h0, fpu_select}, 32'h0);
    chk("fadd_after_flags", {done, busy, bus.req_ready}, 32'b001);

    // frc multi-cycle
    drive(1'b1, 12'h200, 4'h4, 4'h5, 4'h6);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    for (int i = 0; i < 8; i++) begin
      chk("frc_select", 32'(fpu_select), 32'h200);
      chk("frc_owner_ready", {alu_mul_owner, bus.req_ready}, 32'b10);
      chk("frc_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
      tick(); #1;
    end
    chk("frc_end", {20'h0, fpu_select}, 32'h0);
    chk("frc_end_flags", {done, alu_mul_owner, bus.req_ready}, 32'b001);

    // fmul waits behind integer multiplier lock
    int_mul_req = 1'b1; #1;
    chk("int_gnt_idle", 32'(int_mul_gnt), 32'h1);
    tick(); drive(1'b1, 12'h100, 4'h7, 4'h8, 4'h9); #1;
    chk("int_gnt_locked", 32'(int_mul_gnt), 32'h1);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_select", 32'(fpu_select), 32'h0);
      chk("wait_flags", {busy, int_mul_gnt, alu_mul_owner, done, bus.req_ready}, 32'b11000);
      tick(); #1;
    end
    int_mul_req = 1'b0; #1;
    chk("wait_release", {busy, int_mul_gnt, 20'h0, fpu_select}, {2'b10, 20'h0, 12'h000});
    tick(); int_mul_req = 1'b1; #1;
    chk("fmul_select", 32'(fpu_select), 32'h100);
    chk("fmul_flags", {done, alu_mul_owner, int_mul_gnt}, 32'b110);
    chk("fmul_addr", {20'h0, fpu_a_addr, fpu_b_addr, fpu_z_addr}, 32'h789);
`ifdef FPU_SCHED_STATS_EN
    chk("stat_stall", stat_mul_stall, 32'd4);
`endif
    tick(); #1;
    chk("int_regain", {int_mul_gnt, busy}, 32'b10);
    int_mul_req = 1'b0;
    tick();

    // same-cycle contention, FPU priority wins
    int_mul_req = 1'b1; drive(1'b1, 12'h100, 4'h1, 4'h1, 4'h1); #1;
    chk("contend_gnt", 32'(int_mul_gnt), 32'h0);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("contend_exec", {20'h0, fpu_select}, 32'h100);
    chk("contend_flags", {done, int_mul_gnt, alu_mul_owner}, 32'b101);
    tick(); #1;
    chk("contend_after", {int_mul_gnt, busy}, 32'b10);

    // non-mul op runs while integer holds multiplier
    drive(1'b1, 12'h080, 4'h2, 4'h2, 4'h2);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("nonmul_exec", {20'h0, fpu_select}, 32'h080);
    chk("nonmul_flags", {done, int_mul_gnt, alu_mul_owner}, 32'b110);
    int_mul_req = 1'b0;
    tick();

    // bad encodings
    drive(1'b1, 12'h003, 4'h0, 4'h0, 4'h0);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("bad2_flags", {done, done_illegal, busy}, 32'b111);
    chk("bad2_select", 32'(fpu_select), 32'h0);
    tick(); #1;
    chk("bad2_after", {done, done_illegal, busy, bus.req_ready}, 32'b0001);
    drive(1'b1, 12'h000, 4'h0, 4'h0, 4'h0);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("bad0_flags", {done, done_illegal, busy}, 32'b111);
    chk("bad0_select", 32'(fpu_select), 32'h0);
    tick(); #1;
    chk("bad0_after", {done, busy}, 32'b00);

    // cfr illegal flag qualification
    drive(1'b1, 12'h008, 4'h3, 4'h0, 4'h5); fpu_illegal = 1'b1;
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("cfr_ill", {20'h0, done, done_illegal, 10'h0, fpu_select}, {20'h0, 2'b11, 10'h0, 12'h008} >> 0);
    tick(); fpu_illegal = 1'b0; drive(1'b1, 12'h008, 4'h3, 4'h0, 4'h5);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("cfr_ok", {done, done_illegal}, 32'b10);
    tick(); fpu_illegal = 1'b1; drive(1'b1, 12'h040, 4'h0, 4'h0, 4'h0);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0); #1;
    chk("fadd_ill_masked", {done, done_illegal}, 32'b10);
    tick(); fpu_illegal = 1'b0;

`ifdef FPU_SCHED_STATS_EN
    chk("stat_ops", stat_ops, 32'd10);
`endif

    // clr aborts frc in its 3rd execute cycle
    drive(1'b1, 12'h200, 4'hA, 4'hB, 4'hC);
    tick(); drive(1'b0, 12'h000, 4'h0, 4'h0, 4'h0);
    tick(); tick(); clr = 1'b1; #1;
    chk("abort_pre", {20'h0, fpu_select}, 32'h200);
    tick(); #1;
    chk("abort_select", {20'h0, fpu_select}, 32'h0);
    chk("abort_flags", {done, done_illegal, busy, alu_mul_owner, int_mul_gnt}, 32'h0);
    chk("abort_addr", {20'h0, fpu_a_addr, fpu_b_addr, fpu_z_addr}, 32'h0);
`ifdef FPU_SCHED_STATS_EN
    chk("abort_stats", stat_ops | stat_mul_stall, 32'h0);
`endif
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("abort_no_done", {done, busy}, 32'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
